// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one outstanding word read,
// pushes returned words to the instruction queue, handles redirects.
module inst_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  output logic                  req_mem_out,
  output logic [ADDR_WIDTH-1:0] addr_mem_out,
  input  logic                  rdy_mem_in,
  input  logic [31:0]           data_mem_in,
  input  logic                  iqfull_iq_in,
  output logic                  rdy_inst_iq_out,
  output logic [31:0]           inst_iq_out,
  output logic [ADDR_WIDTH-1:0] pc_iq_out,
  input  logic                  refresh_rob_cdb_in,
  input  logic [ADDR_WIDTH-1:0] pc_rob_cdb_in
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      req_mem_out     <= 1'b0;
      addr_mem_out    <= '0;
      rdy_inst_iq_out <= 1'b0;
      inst_iq_out     <= '0;
      pc_iq_out       <= '0;
    end else if (!rdy_in) begin
      rdy_inst_iq_out <= 1'b0;
    end else begin
      rdy_inst_iq_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (refresh_rob_cdb_in) begin
            pc <= pc_rob_cdb_in;
          end else if (!iqfull_iq_in) begin
            req_mem_out  <= 1'b1;
            addr_mem_out <= pc;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (refresh_rob_cdb_in) begin
            pc          <= pc_rob_cdb_in;
            req_mem_out <= 1'b0;
            state       <= rdy_mem_in ? IDLE : DROP;
          end else if (rdy_mem_in) begin
            rdy_inst_iq_out <= 1'b1;
            inst_iq_out     <= data_mem_in;
            pc_iq_out       <= pc;
            pc              <= pc + ADDR_WIDTH'(4);
            req_mem_out     <= 1'b0;
            state           <= IDLE;
          end
        end
        DROP: begin
          // Stale response still owed; swallow it before refetching.
          if (refresh_rob_cdb_in) pc <= pc_rob_cdb_in;
          if (rdy_mem_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl.
// Inputs change 1ns after posedge; outputs sampled there too.
module tb_inst_fetch_ctrl;

  localparam int AW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          req_mem_out;
  logic [AW-1:0] addr_mem_out;
  logic          rdy_mem_in;
  logic [31:0]   data_mem_in;
  logic          iqfull_iq_in;
  logic          rdy_inst_iq_out;
  logic [31:0]   inst_iq_out;
  logic [AW-1:0] pc_iq_out;
  logic          refresh_rob_cdb_in;
  logic [AW-1:0] pc_rob_cdb_in;

  int n_cmp = 0;
  int n_bad = 0;

  inst_fetch_ctrl #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .req_mem_out(req_mem_out),
    .addr_mem_out(addr_mem_out),
    .rdy_mem_in(rdy_mem_in),
    .data_mem_in(data_mem_in),
    .iqfull_iq_in(iqfull_iq_in),
    .rdy_inst_iq_out(rdy_inst_iq_out),
    .inst_iq_out(inst_iq_out),
    .pc_iq_out(pc_iq_out),
    .refresh_rob_cdb_in(refresh_rob_cdb_in),
    .pc_rob_cdb_in(pc_rob_cdb_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (req_mem_out === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    rdy_mem_in = 1'b0;
    data_mem_in = '0;
    iqfull_iq_in = 1'b1;
    refresh_rob_cdb_in = 1'b0;
    pc_rob_cdb_in = '0;
    step();
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (req_mem_out !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_req got %b want 0", req_mem_out);
    end
    n_cmp++;
    if (addr_mem_out !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_addr got %h want 0", addr_mem_out);
    end
    n_cmp++;
    if (rdy_inst_iq_out !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_push got %b want 0", rdy_inst_iq_out);
    end
    n_cmp++;
    if (inst_iq_out !== 32'h0 || pc_iq_out !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_iq got %h/%h want 0/0",
               inst_iq_out, pc_iq_out);
    end
  endtask

  task automatic test_stream();
    bit ok;
    logic [31:0] exp_pc;
    iqfull_iq_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'(k * 4);
      wait_req(ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL strm_req_timeout got 0 want 1");
      end
      n_cmp++;
      if (addr_mem_out !== exp_pc) begin
        n_bad++;
        $display("FAIL strm_addr got %h want %h",
                 addr_mem_out, exp_pc);
      end
      step();
      step();
      n_cmp++;
      if (req_mem_out !== 1'b1 || addr_mem_out !== exp_pc) begin
        n_bad++;
        $display("FAIL strm_hold got %b/%h want 1/%h",
                 req_mem_out, addr_mem_out, exp_pc);
      end
      rdy_mem_in = 1'b1;
      data_mem_in = exp_pc ^ 32'hA5A5_0000;
      if (k == 2) iqfull_iq_in = 1'b1;
      step();
      rdy_mem_in = 1'b0;
      n_cmp++;
      if (rdy_inst_iq_out !== 1'b1) begin
        n_bad++;
        $display("FAIL strm_push got %b want 1", rdy_inst_iq_out);
      end
      n_cmp++;
      if (inst_iq_out !== (exp_pc ^ 32'hA5A5_0000)
          || pc_iq_out !== exp_pc) begin
        n_bad++;
        $display("FAIL strm_data got %h/%h want %h/%h",
                 inst_iq_out, pc_iq_out,
                 exp_pc ^ 32'hA5A5_0000, exp_pc);
      end
      n_cmp++;
      if (req_mem_out !== 1'b0) begin
        n_bad++;
        $display("FAIL strm_req_drop got %b want 0", req_mem_out);
      end
      step();
      n_cmp++;
      if (rdy_inst_iq_out !== 1'b0
          || inst_iq_out !== (exp_pc ^ 32'hA5A5_0000)) begin
        n_bad++;
        $display("FAIL strm_one_shot got %b/%h want 0/%h",
                 rdy_inst_iq_out, inst_iq_out,
                 exp_pc ^ 32'hA5A5_0000);
      end
    end
  endtask

  task automatic test_iqfull();
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (req_mem_out !== 1'b0) begin
        n_bad++;
        $display("FAIL full_req cyc %0d got %b want 0",
                 i, req_mem_out);
      end
    end
    iqfull_iq_in = 1'b0;
    step();
    n_cmp++;
    if (req_mem_out !== 1'b1 || addr_mem_out !== 32'hC) begin
      n_bad++;
      $display("FAIL full_release got %b/%h want 1/0000000c",
               req_mem_out, addr_mem_out);
    end
  endtask

  task automatic test_refresh_drop();
    do_reset();
    refresh_rob_cdb_in = 1'b1;
    pc_rob_cdb_in = 32'h8;
    step();
    refresh_rob_cdb_in = 1'b0;
    iqfull_iq_in = 1'b0;
    n_cmp++;
    if (req_mem_out !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ref_req got %b want 0", req_mem_out);
    end
    step();
    n_cmp++;
    if (req_mem_out !== 1'b1 || addr_mem_out !== 32'h8) begin
      n_bad++;
      $display("FAIL idle_ref_addr got %b/%h want 1/00000008",
               req_mem_out, addr_mem_out);
    end
    step();
    refresh_rob_cdb_in = 1'b1;
    pc_rob_cdb_in = 32'h100;
    step();
    refresh_rob_cdb_in = 1'b0;
    n_cmp++;
    if (req_mem_out !== 1'b0 || rdy_inst_iq_out !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_enter got %b/%b want 0/0",
               req_mem_out, rdy_inst_iq_out);
    end
    step();
    step();
    n_cmp++;
    if (req_mem_out !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_no_req got %b want 0", req_mem_out);
    end
    rdy_mem_in = 1'b1;
    data_mem_in = 32'hDEAD_BEEF;
    step();
    rdy_mem_in = 1'b0;
    n_cmp++;
    if (rdy_inst_iq_out !== 1'b0 || inst_iq_out !== 32'h0) begin
      n_bad++;
      $display("FAIL drop_stale got %b/%h want 0/00000000",
               rdy_inst_iq_out, inst_iq_out);
    end
    step();
    n_cmp++;
    if (req_mem_out !== 1'b1 || addr_mem_out !== 32'h100) begin
      n_bad++;
      $display("FAIL drop_next got %b/%h want 1/00000100",
               req_mem_out, addr_mem_out);
    end
  endtask

  task automatic test_refresh_same();
    step();
    rdy_mem_in = 1'b1;
    data_mem_in = 32'h1234_5678;
    refresh_rob_cdb_in = 1'b1;
    pc_rob_cdb_in = 32'h40;
    step();
    rdy_mem_in = 1'b0;
    refresh_rob_cdb_in = 1'b0;
    n_cmp++;
    if (rdy_inst_iq_out !== 1'b0 || inst_iq_out !== 32'h0) begin
      n_bad++;
      $display("FAIL same_push got %b/%h want 0/00000000",
               rdy_inst_iq_out, inst_iq_out);
    end
    n_cmp++;
    if (req_mem_out !== 1'b0) begin
      n_bad++;
      $display("FAIL same_req got %b want 0", req_mem_out);
    end
    step();
    n_cmp++;
    if (req_mem_out !== 1'b1 || addr_mem_out !== 32'h40) begin
      n_bad++;
      $display("FAIL same_next got %b/%h want 1/00000040",
               req_mem_out, addr_mem_out);
    end
  endtask

  task automatic test_hold();
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (req_mem_out !== 1'b1 || addr_mem_out !== 32'h40
          || rdy_inst_iq_out !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_wait cyc %0d got %b/%h/%b want 1/40/0",
                 i, req_mem_out, addr_mem_out, rdy_inst_iq_out);
      end
    end
    rdy_in = 1'b1;
    step();
    rdy_mem_in = 1'b1;
    data_mem_in = 32'h40 ^ 32'hA5A5_0000;
    step();
    rdy_mem_in = 1'b0;
    rdy_in = 1'b0;
    n_cmp++;
    if (rdy_inst_iq_out !== 1'b1 || inst_iq_out !== 32'hA5A5_0040
        || pc_iq_out !== 32'h40) begin
      n_bad++;
      $display("FAIL hold_push got %b/%h/%h want 1/a5a50040/40",
               rdy_inst_iq_out, inst_iq_out, pc_iq_out);
    end
    step();
    step();
    n_cmp++;
    if (req_mem_out !== 1'b0 || rdy_inst_iq_out !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_idle got %b/%b want 0/0",
               req_mem_out, rdy_inst_iq_out);
    end
    rdy_in = 1'b1;
    step();
    n_cmp++;
    if (req_mem_out !== 1'b1 || addr_mem_out !== 32'h44) begin
      n_bad++;
      $display("FAIL hold_resume got %b/%h want 1/00000044",
               req_mem_out, addr_mem_out);
    end
  endtask

  task automatic test_async_reset();
    step();
    #3;
    rst_in = 1'b1;
    #1;
    n_cmp++;
    if (req_mem_out !== 1'b0 || addr_mem_out !== 32'h0
        || pc_iq_out !== 32'h0 || inst_iq_out !== 32'h0) begin
      n_bad++;
      $display("FAIL arst_now got %b/%h/%h/%h want 0/0/0/0",
               req_mem_out, addr_mem_out, pc_iq_out, inst_iq_out);
    end
    #1;
    rst_in = 1'b0;
    step();
    n_cmp++;
    if (req_mem_out !== 1'b1 || addr_mem_out !== 32'h0) begin
      n_bad++;
      $display("FAIL arst_first got %b/%h want 1/00000000",
               req_mem_out, addr_mem_out);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    refresh_rob_cdb_in = 1'b1;
    pc_rob_cdb_in = 32'hFFFF_FFFC;
    step();
    refresh_rob_cdb_in = 1'b0;
    iqfull_iq_in = 1'b0;
    step();
    n_cmp++;
    if (addr_mem_out !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL wrap_addr got %h want fffffffc", addr_mem_out);
    end
    rdy_mem_in = 1'b1;
    data_mem_in = 32'h0000_0013;
    step();
    rdy_mem_in = 1'b0;
    n_cmp++;
    if (rdy_inst_iq_out !== 1'b1 || pc_iq_out !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL wrap_push got %b/%h want 1/fffffffc",
               rdy_inst_iq_out, pc_iq_out);
    end
    step();
    n_cmp++;
    if (req_mem_out !== 1'b1 || addr_mem_out !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_next got %b/%h want 1/00000000",
               req_mem_out, addr_mem_out);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_iqfull();
    test_refresh_drop();
    test_refresh_same();
    test_hold();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
